// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples SCK/WS/SD on the system clock, recovers
// left-justified stereo samples and presents each L/R pair over valid/ready.
module i2s_slave_rx #(
  parameter int DATA_W      = 16,
  parameter int MAX_SLOT    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              i2s_sck,
  input  logic              i2s_ws,
  input  logic              i2s_sd,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(MAX_SLOT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC_WAIT,
    S_LEFT,
    S_RIGHT
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_sck_prev;
  logic                   r_ws_last;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_shift;
  logic [DATA_W-1:0]      r_left_hold;

  logic w_sck;
  logic w_ws;
  logic w_sd;
  logic w_sck_fall;
  logic w_ws_chg;
  logic w_slot_full;
  logic w_pair_done;
  logic w_accept;

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_ws        = r_ws_sync[SYNC_STAGES-1];
  assign w_sd        = r_sd_sync[SYNC_STAGES-1];
  assign w_sck_fall  = r_sck_prev & ~w_sck;
  assign w_ws_chg    = w_sck_fall & (w_ws != r_ws_last);
  assign w_slot_full = (r_bit_cnt >= CNT_W'(DATA_W));
  // A RIGHT-state WS change can only be a rise, so it always ends the pair.
  assign w_pair_done = enable & (r_state == S_RIGHT) & w_ws_chg & w_slot_full;
  assign w_accept    = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_sync  <= '0;
      r_sck_prev <= 1'b0;
      r_ws_last  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage take its pre-edge
      // neighbour, so the chain advances exactly one flop per clk.
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i2s_sck};
      r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], i2s_ws};
      r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], i2s_sd};
      r_sck_prev <= w_sck;
      if (w_sck_fall) r_ws_last <= w_ws;
    end
  end

  // Slot bit counter and MSB-first shift register; pad bits past DATA_W are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (!enable) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_sck_fall) begin
      if (w_ws_chg) begin
        r_bit_cnt <= CNT_W'(1);
        r_shift   <= {{(DATA_W-1){1'b0}}, w_sd};
      end else begin
        if (r_bit_cnt < CNT_W'(DATA_W)) r_shift <= {r_shift[DATA_W-2:0], w_sd};
        if (r_bit_cnt < CNT_W'(MAX_SLOT)) r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_left_hold <= '0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (!enable) begin
        r_state     <= S_IDLE;
        r_left_hold <= '0;
      end else if (w_sck_fall) begin
        case (r_state)
          // The first sampled WS only seeds r_ws_last; a real 0->1 is still required.
          S_IDLE: r_state <= S_SYNC_WAIT;
          S_SYNC_WAIT: begin
            if (w_ws_chg && w_ws) r_state <= S_LEFT;
          end
          S_LEFT: begin
            if (w_ws_chg) begin
              if (w_slot_full) begin
                r_left_hold <= r_shift;
                r_state     <= S_RIGHT;
              end else begin
                frame_err <= 1'b1;
                r_state   <= S_SYNC_WAIT;
              end
            end
          end
          S_RIGHT: begin
            if (w_ws_chg) begin
              if (!w_slot_full) frame_err <= 1'b1;
              r_state <= S_LEFT;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Output pair register: independent of enable so a pending handshake can finish.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      left_data  <= '0;
      right_data <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_pair_done) begin
        if (w_accept) begin
          left_data  <= r_left_hold;
          right_data <= r_shift;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Self-checking bench for i2s_slave_rx: a bit-level I2S transmitter drives the
// DUT and a slot-level reference model predicts pairs, frame errors and overruns.
module tb_i2s_slave_rx;

  localparam int DATA_W      = 16;
  localparam int MAX_SLOT    = 32;
  localparam int SYNC_STAGES = 2;

  typedef struct {
    bit          ws;
    logic [15:0] data;
    int          nbits;
  } slot_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        i2s_sck = 1'b0;
  logic        i2s_ws = 1'b0;
  logic        i2s_sd = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] left_data;
  logic [15:0] right_data;
  logic        out_valid;
  logic        overrun;
  logic        frame_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  slot_t       slots[$];
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  int          exp_ferr;
  int          n_ovr = 0;
  int          n_ferr = 0;
  int          base_got, base_ovr, base_ferr;

  i2s_slave_rx #(
    .DATA_W(DATA_W), .MAX_SLOT(MAX_SLOT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .left_data(left_data), .right_data(right_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Consumer-side monitor: accepted pairs and pulse-cycle counts.
  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back({left_data, right_data});
    if (overrun) n_ovr++;
    if (frame_err) n_ferr++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends bits first..nbits-1 of one slot: data MSB first, then pad bits.
  task automatic tx_slot(input bit ws, input logic [15:0] data, input int nbits,
                         input bit pad, input int first, input bit lat);
    for (int i = first; i < nbits; i++) begin
      i2s_sck = 1'b1;
      i2s_ws  = ws;
      i2s_sd  = (i < 16) ? data[15-i] : pad;
      step(4);
      i2s_sck = 1'b0;
      if (lat && i == first) begin
        // Strobe appears after SYNC_STAGES clks; out_valid one clk later.
        repeat (SYNC_STAGES + 1) @(negedge clk);
        check("lat_early", out_valid, 1'b0);
        @(negedge clk);
        check("lat_rise", out_valid, 1'b1);
        step(1);
      end else begin
        step(4);
      end
    end
    slots.push_back('{ws, data, nbits});
  endtask

  // Slot-level model: a slot ends when the next (opposite-WS) slot starts.
  task automatic run_model();
    int          phase;
    logic [15:0] lh;
    exp_q.delete();
    exp_ferr = 0;
    phase = 0;
    lh = '0;
    for (int k = 1; k < slots.size(); k++) begin
      if (phase == 0) begin
        if (slots[k].ws) phase = 1;
      end else if (phase == 1) begin
        if (slots[k-1].nbits >= DATA_W) begin
          lh = slots[k-1].data;
          phase = 2;
        end else begin
          exp_ferr++;
          phase = 0;
        end
      end else begin
        if (slots[k-1].nbits >= DATA_W) exp_q.push_back({lh, slots[k-1].data});
        else exp_ferr++;
        phase = 1;
      end
    end
  endtask

  task automatic begin_episode(input bit rdy);
    slots.delete();
    base_got  = got.size();
    base_ovr  = n_ovr;
    base_ferr = n_ferr;
    out_ready = rdy;
    enable    = 1'b1;
  endtask

  task automatic end_episode(input string tag, input bit rdy);
    run_model();
    check({tag, "_ferr"}, n_ferr - base_ferr, exp_ferr);
    if (rdy) begin
      check({tag, "_ovr"}, n_ovr - base_ovr, 0);
      check({tag, "_npairs"}, got.size() - base_got, exp_q.size());
      foreach (exp_q[i])
        if (base_got + i < got.size())
          check($sformatf("%s_pair%0d", tag, i), got[base_got+i], exp_q[i]);
    end else if (exp_q.size() > 0) begin
      check({tag, "_ovr"}, n_ovr - base_ovr, exp_q.size() - 1);
      check({tag, "_held"}, {left_data, right_data}, exp_q[0]);
      check({tag, "_held_valid"}, out_valid, 1'b1);
    end else begin
      check({tag, "_no_valid"}, out_valid, 1'b0);
    end
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  initial begin
    logic [15:0] d;

    // Reset state
    step(2);
    @(negedge clk);
    check("rst_left", left_data, 16'h0);
    check("rst_right", right_data, 16'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_flags", {overrun, frame_err}, 2'b00);
    step(1);
    rstn = 1'b1;
    step(2);

    // 1: basic pair with exact latency
    begin_episode(1'b1);
    tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, 16'hA5C3, 18, 1'b0, 0, 1'b0);
    tx_slot(1'b0, 16'h3C5A, 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b1);
    end_episode("t1", 1'b1);
    check("t1_data", {left_data, right_data}, 32'hA5C3_3C5A);

    // 2: enable mid right slot
    enable = 1'b0;
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    d = rnd16();
    tx_slot(1'b0, d, 7, 1'b0, 0, 1'b0);
    begin_episode(1'b1);
    tx_slot(1'b0, d, 18, 1'b0, 7, 1'b0);
    for (int p = 0; p < 2; p++) begin
      tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
      tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
    end
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    end_episode("t2", 1'b1);

    // 3: consumer stalled across two completions
    enable = 1'b0;
    step(2);
    begin_episode(1'b0);
    tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, 16'h1111, 18, 1'b0, 0, 1'b0);
    tx_slot(1'b0, 16'h2222, 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, 16'h3333, 18, 1'b0, 0, 1'b0);
    tx_slot(1'b0, 16'h4444, 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    end_episode("t3", 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_at_accept", out_valid, 1'b1);
    @(negedge clk);
    check("t3_valid_fall", out_valid, 1'b0);
    check("t3_accepted", got.size() > 0 ? got[got.size()-1] : 32'h0, 32'h1111_2222);
    step(1);

    // 4: short left slot, then short right slot
    enable = 1'b0;
    step(2);
    begin_episode(1'b1);
    tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 10, 1'b0, 0, 1'b0);
    tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b0, rnd16(), 12, 1'b0, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    end_episode("t4", 1'b1);

    // 5: long slots with padding ones, counter saturation, back-to-back
    enable = 1'b0;
    step(2);
    begin_episode(1'b1);
    tx_slot(1'b0, rnd16(), 32, 1'b1, 0, 1'b0);
    tx_slot(1'b1, 16'hFFFF, 32, 1'b1, 0, 1'b0);
    tx_slot(1'b0, 16'hFFFF, 32, 1'b1, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 40, 1'b1, 0, 1'b0);
    check("t5_cnt_sat", dut.r_bit_cnt, 64'(MAX_SLOT));
    tx_slot(1'b0, rnd16(), 40, 1'b1, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    end_episode("t5", 1'b1);

    // 6: reset pulse mid left slot while a pair is held
    enable = 1'b0;
    step(2);
    begin_episode(1'b0);
    tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
    d = rnd16();
    tx_slot(1'b1, d, 9, 1'b0, 0, 1'b0);
    end_episode("t6a", 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("t6_rst_outs", {left_data, right_data, out_valid, overrun, frame_err}, 35'h0);
    step(3);
    rstn = 1'b1;
    begin_episode(1'b1);
    tx_slot(1'b1, d, 18, 1'b0, 9, 1'b0);
    for (int p = 0; p < 3; p++) begin
      tx_slot(1'b0, rnd16(), 18, 1'b0, 0, 1'b0);
      tx_slot(1'b1, rnd16(), 18, 1'b0, 0, 1'b0);
    end
    end_episode("t6b", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
